mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
- Multi-cycle CPU control unit.
- Sequences the shared ALU datapath: PC, IR, A/B registers, branch-target register, ALU and a single unified memory.
- Each cycle it drives the ALU operand selects: alu_src_b_sel steers the 4-input operand-B mux (0=B reg, 1=constant 1, 2=sign-extended imm, 3=jump address); alu_src_a_sel steers operand A.
- Also drives the write strobes and the memory handshake, including wait states and a timeout.

Parameters:
- OPW, 6, opcode width.
- TMO, 16, maximum cycles to wait for mem_ready; 0 disables the timeout.
- CW, 5, width of the wait counter; must hold TMO.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  leave IDLE and begin fetching when high.
- opcode  in  OPW  IR[31:26]; valid from DECODE onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current read/write this cycle.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- iord  out  1  address source: 0=PC, 1=ALUOut.
- ir_write  out  1  load IR.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load qualified by zero (BEQ).
- pc_src  out  1  PC source: 0=ALU result, 1=target register.
- target_write  out  1  load branch-target register.
- alu_src_a_sel  out  2  operand A: 0=PC, 1=A reg, 2=zero.
- alu_src_b_sel  out  2  operand-B mux select (encoding above).
- alu_op  out  2  0=ADD, 1=SUB, 2=use funct field.
- reg_write  out  1  register-file write enable.
- reg_dst  out  1  write address: 0=rt, 1=rd.
- mem_to_reg  out  1  write data: 0=ALUOut, 1=MDR.
- illegal_op  out  1  one-cycle pulse when DECODE sees an undefined opcode.
- mem_err  out  1  sticky timeout error; cleared only by reset.
- state  out  3  current state, for debug.

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5. Registered state; outputs are a combinational decode of state and opcode (Moore-style). Any output not listed for a state is 0.
- Reset (async, rst_n low): state=IDLE, wait counter=0, mem_err=0. Every output is 0 while in reset and in IDLE, including alu_src_b_sel=0.
- IDLE: if run=1 and mem_err=0, go to FETCH next edge; otherwise hold.
- FETCH:
  - mem_read=1, iord=0, alu_src_a_sel=0, alu_src_b_sel=1, alu_op=ADD (PC+1; memory is word-addressed).
  - ir_write and pc_write are asserted only in a cycle where mem_ready=1; then go to DECODE.
  - Otherwise stay in FETCH and increment the wait counter.
- DECODE (always one cycle):
  - Supported opcodes: RTYPE=00, ADDI=08, LW=23, SW=2B, BEQ=04 → alu_src_a_sel=0, alu_src_b_sel=2, alu_op=ADD, target_write=1; go to EXEC.
  - J=02 → alu_src_a_sel=2, alu_src_b_sel=3, alu_op=ADD, pc_write=1, pc_src=0; go to FETCH.
  - Any other opcode → illegal_op=1, no writes; go to FETCH (instruction skipped).
- EXEC (always one cycle):
  - RTYPE: a=1, b=0, alu_op=2; go to WB.
  - ADDI: a=1, b=2, ADD; go to WB.
  - LW/SW: a=1, b=2, ADD; go to MEM.
  - BEQ: a=1, b=0, SUB, pc_write_cond=1, pc_src=1; go to FETCH.
- MEM:
  - iord=1; LW drives mem_read=1, SW drives mem_write=1.
  - On mem_ready: LW goes to WB; SW goes to FETCH.
  - Otherwise hold and increment the wait counter.
- WB:
  - reg_write=1.
  - reg_dst=1 for RTYPE, else 0.
  - mem_to_reg=1 for LW, else 0.
  - Go to FETCH.
- Wait counter:
  - Cleared on every state change.
  - If TMO≠0 and the counter reaches TMO-1 while still waiting with mem_ready=0, the next edge sets mem_err=1 and enters IDLE. No strobe is issued on that edge.
  - mem_ready=1 on the TMO-th wait cycle still completes normally.
- Zero-wait memory: mem_ready already high on the first FETCH/MEM cycle gives single-cycle completion.
- Cycle counts with zero wait states: R/ADDI=4, LW=5, SW=4, BEQ=3, J=2, illegal=2.
- run is sampled only in IDLE; deasserting run mid-instruction has no effect.
- rst_n asserted mid-transaction drops every strobe immediately (asynchronous), including an outstanding mem_write.

Decomposition:
- Shared package/include cpu_defs: opcode constants, state encodings, alu_op encodings, and the ALU operand-select encodings (SRCB_B=0, SRCB_ONE=1, SRCB_IMM=2, SRCB_ADDR=3; SRCA_PC=0, SRCA_A=1, SRCA_ZERO=2). The datapath muxes use the same encodings.
- One natural sub-module: mem_wait_timer (counter, TMO compare, sticky mem_err).

Test Plan:
- Reset then run=1, mem_ready tied 1, opcode=00 → states 1,2,3,5,1. FETCH cycle: alu_src_b_sel=1, ir_write=1, pc_write=1. EXEC: alu_src_b_sel=0, alu_op=2. WB: reg_write=1, reg_dst=1.
- LW (23) with mem_ready low for 3 cycles in MEM → mem_read held 4 cycles with iord=1; WB has mem_to_reg=1, reg_dst=0; total 8 cycles.
- BEQ (04) then J (02) → BEQ EXEC: alu_op=1, pc_write_cond=1, pc_src=1. J DECODE: alu_src_b_sel=3, alu_src_a_sel=2, pc_write=1; back in FETCH next cycle.
- Opcode 3F → illegal_op high exactly one cycle in DECODE, no write strobes, next state FETCH.
- TMO=16, mem_ready stuck low in FETCH → after 16 FETCH cycles: mem_err=1, state=IDLE, all outputs 0; run=1 is ignored until rst_n is pulsed.
- SW with rst_n pulsed low in the middle of MEM → mem_write drops asynchronously; after release, state=IDLE and mem_err=0.

Source files
------------

// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle CPU control unit and its datapath.
// Latency: n/a (constants and a pure helper only).
// Backpressure: n/a. The datapath muxes decode the same SRCA_*/SRCB_*/ALU_* values.
package mc_ctrl_fsm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] SRCA_PC   = 2'd0;
    localparam logic [1:0] SRCA_A    = 2'd1;
    localparam logic [1:0] SRCA_ZERO = 2'd2;

    localparam logic [1:0] SRCB_B    = 2'd0;
    localparam logic [1:0] SRCB_ONE  = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;
    localparam logic [1:0] SRCB_ADDR = 2'd3;

    // Opcodes that take the DECODE -> EXEC path (J and illegal ones do not).
    function automatic logic is_exec_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW) ||
               (op == OP_SW)    || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control-unit <-> datapath/memory signal bundle.
// master: the controller (drives strobes/selects); slave: datapath and memory side.
// Backpressure: memory stalls the controller through mem_ready.
interface mc_ctrl_fsm_if #(
    parameter int OPW = 6
);
    logic           run;
    logic [OPW-1:0] opcode;
    logic           zero;
    logic           mem_ready;
    logic           mem_read;
    logic           mem_write;
    logic           iord;
    logic           ir_write;
    logic           pc_write;
    logic           pc_write_cond;
    logic           pc_src;
    logic           target_write;
    logic [1:0]     alu_src_a_sel;
    logic [1:0]     alu_src_b_sel;
    logic [1:0]     alu_op;
    logic           reg_write;
    logic           reg_dst;
    logic           mem_to_reg;
    logic           illegal_op;
    logic           mem_err;
    logic [2:0]     state;

    modport master (
        input  run, opcode, zero, mem_ready,
        output mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond,
               pc_src, target_write, alu_src_a_sel, alu_src_b_sel, alu_op,
               reg_write, reg_dst, mem_to_reg, illegal_op, mem_err, state
    );

    modport slave (
        output run, opcode, zero, mem_ready,
        input  mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond,
               pc_src, target_write, alu_src_a_sel, alu_src_b_sel, alu_op,
               reg_write, reg_dst, mem_to_reg, illegal_op, mem_err, state
    );
endinterface

// File: rtl/mc_ctrl_fsm_mem_wait_timer.sv
// Memory wait-state counter with timeout compare and sticky error flag.
// Latency: timeout_o is combinational from the count; mem_err_o sets on the following edge.
// Backpressure: counts cycles spent waiting on mem_ready; clr_i restarts on any state change.
// Ports: clk/rst_n, waiting_i (in FETCH/MEM), mem_ready_i, clr_i, timeout_o, mem_err_o.
module mem_wait_timer #(
    parameter int TMO = 16,
    parameter int CW  = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic waiting_i,
    input  logic mem_ready_i,
    input  logic clr_i,
    output logic timeout_o,
    output logic mem_err_o
);
    logic [CW-1:0] cnt_q;
    logic          mem_err_q;
    logic          stalled;

    assign stalled = waiting_i && !mem_ready_i;

    // Fires in the TMO-th stalled cycle; a ready in that same cycle wins.
    assign timeout_o = (TMO != 0) && stalled && (cnt_q == CW'(TMO - 1));
    assign mem_err_o = mem_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            if (clr_i) begin
                cnt_q <= '0;
            end else if (stalled) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (timeout_o) begin
                mem_err_q <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle CPU control unit: sequences PC/IR/A/B/target regs, ALU and unified memory.
// Latency: Moore outputs decoded from registered state (+opcode, +mem_ready for fetch strobes).
// Backpressure: holds FETCH/MEM while mem_ready is low; times out to IDLE with sticky mem_err.
// Ports: clk, rst_n (async active-low), bus (master side of mc_ctrl_fsm_if).
module mc_ctrl_fsm
    import mc_ctrl_fsm_pkg::*;
#(
    parameter int OPW = 6,
    parameter int TMO = 16,
    parameter int CW  = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    mc_ctrl_fsm_if.master  bus
);
    state_e     state_q, state_d;
    logic [5:0] op;
    logic       timeout;
    logic       mem_err;
    logic       waiting;
    logic       clr;

    assign op      = 6'(bus.opcode);
    assign waiting = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign clr     = (state_d != state_q);

    mem_wait_timer #(
        .TMO (TMO),
        .CW  (CW)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .waiting_i   (waiting),
        .mem_ready_i (bus.mem_ready),
        .clr_i       (clr),
        .timeout_o   (timeout),
        .mem_err_o   (mem_err)
    );

    assign bus.mem_err = mem_err;
    assign bus.state   = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // zero is consumed by the datapath to qualify pc_write_cond; not needed here.
    always_comb begin
        state_d           = state_q;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.iord          = 1'b0;
        bus.ir_write      = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.pc_src        = 1'b0;
        bus.target_write  = 1'b0;
        bus.alu_src_a_sel = SRCA_PC;
        bus.alu_src_b_sel = SRCB_B;
        bus.alu_op        = ALU_ADD;
        bus.reg_write     = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.illegal_op    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.run && !mem_err) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                // PC+1: memory is word-addressed.
                bus.mem_read      = 1'b1;
                bus.alu_src_b_sel = SRCB_ONE;
                if (timeout) begin
                    state_d = ST_IDLE;
                end else if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    state_d      = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (is_exec_op(op)) begin
                    // Speculative branch target PC+imm, harmless for non-branches.
                    bus.alu_src_b_sel = SRCB_IMM;
                    bus.target_write  = 1'b1;
                    state_d           = ST_EXEC;
                end else if (op == OP_J) begin
                    bus.alu_src_a_sel = SRCA_ZERO;
                    bus.alu_src_b_sel = SRCB_ADDR;
                    bus.pc_write      = 1'b1;
                    state_d           = ST_FETCH;
                end else begin
                    bus.illegal_op = 1'b1;
                    state_d        = ST_FETCH;
                end
            end
            ST_EXEC: begin
                bus.alu_src_a_sel = SRCA_A;
                state_d           = ST_FETCH;
                case (op)
                    OP_RTYPE: begin
                        bus.alu_op = ALU_FUNCT;
                        state_d    = ST_WB;
                    end
                    OP_ADDI: begin
                        bus.alu_src_b_sel = SRCB_IMM;
                        state_d           = ST_WB;
                    end
                    OP_LW, OP_SW: begin
                        bus.alu_src_b_sel = SRCB_IMM;
                        state_d           = ST_MEM;
                    end
                    OP_BEQ: begin
                        bus.alu_op        = ALU_SUB;
                        bus.pc_write_cond = 1'b1;
                        bus.pc_src        = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                bus.iord      = 1'b1;
                bus.mem_read  = (op == OP_LW);
                bus.mem_write = (op == OP_SW);
                if (op != OP_LW && op != OP_SW) begin
                    state_d = ST_FETCH;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                end else if (bus.mem_ready) begin
                    state_d = (op == OP_LW) ? ST_WB : ST_FETCH;
                end
            end
            ST_WB: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = (op == OP_RTYPE);
                bus.mem_to_reg = (op == OP_LW);
                state_d        = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: walks each instruction class, wait states,
// timeout, and asynchronous reset mid-transaction against hand-computed values.
module tb_mc_ctrl_fsm;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_mis;

    mc_ctrl_fsm_if #(.OPW(6)) bus ();

    mc_ctrl_fsm #(
        .OPW (6),
        .TMO (16),
        .CW  (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All outputs except state, mem_err in bit 0.
    function automatic logic [18:0] outs();
        return {bus.mem_read, bus.mem_write, bus.iord, bus.ir_write, bus.pc_write,
                bus.pc_write_cond, bus.pc_src, bus.target_write,
                bus.alu_src_a_sel, bus.alu_src_b_sel, bus.alu_op,
                bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.illegal_op, bus.mem_err};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_cmp = 0;
        n_mis = 0;
        rst_n = 1'b0;
        bus.run = 1'b0;
        bus.opcode = 6'h00;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;
        #3;
        check_eq("rst_state", bus.state, 0);
        check_eq("rst_outs", outs(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("idle_hold", bus.state, 0);

        // ---------------- R-type, zero wait ----------------
        bus.run = 1'b1;
        bus.mem_ready = 1'b1;
        bus.opcode = 6'h00;
        tick();
        bus.run = 1'b0;
        check_eq("r_fetch_state", bus.state, 1);
        check_eq("r_fetch_bsel", bus.alu_src_b_sel, 1);
        check_eq("r_fetch_ir_pc", {bus.ir_write, bus.pc_write, bus.mem_read, bus.iord}, 4'b1110);
        tick();
        check_eq("r_dec_state", bus.state, 2);
        check_eq("r_dec_tgt_bsel", {bus.target_write, bus.alu_src_b_sel}, 3'b110);
        tick();
        check_eq("r_exec_state", bus.state, 3);
        check_eq("r_exec_sel", {bus.alu_src_a_sel, bus.alu_src_b_sel, bus.alu_op}, 6'b01_00_10);
        tick();
        check_eq("r_wb_state", bus.state, 5);
        check_eq("r_wb_ctl", {bus.reg_write, bus.reg_dst, bus.mem_to_reg}, 3'b110);
        tick();
        check_eq("r_back_fetch", bus.state, 1);

        // ---------------- LW with 3 wait states in MEM ----------------
        bus.opcode = 6'h23;
        tick();
        check_eq("lw_dec_state", bus.state, 2);
        tick();
        check_eq("lw_exec_sel", {bus.alu_src_a_sel, bus.alu_src_b_sel, bus.alu_op}, 6'b01_10_00);
        bus.mem_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (i == 4) bus.mem_ready = 1'b1;
            #1;
            check_eq($sformatf("lw_mem%0d", i),
                     {bus.state, bus.mem_read, bus.mem_write, bus.iord}, {3'd4, 3'b101});
        end
        tick();
        check_eq("lw_wb_state", bus.state, 5);
        check_eq("lw_wb_ctl", {bus.reg_write, bus.reg_dst, bus.mem_to_reg}, 3'b101);
        tick();
        check_eq("lw_back_fetch", bus.state, 1);

        // ---------------- BEQ then J ----------------
        bus.opcode = 6'h04;
        tick();
        tick();
        check_eq("beq_exec_state", bus.state, 3);
        check_eq("beq_exec_ctl",
                 {bus.alu_op, bus.pc_write_cond, bus.pc_src, bus.alu_src_a_sel, bus.alu_src_b_sel},
                 8'b01_1_1_01_00);
        tick();
        check_eq("beq_back_fetch", bus.state, 1);
        bus.opcode = 6'h02;
        tick();
        check_eq("j_dec_state", bus.state, 2);
        check_eq("j_dec_ctl",
                 {bus.alu_src_a_sel, bus.alu_src_b_sel, bus.pc_write, bus.pc_src, bus.target_write},
                 7'b10_11_1_0_0);
        tick();
        check_eq("j_back_fetch", bus.state, 1);

        // ---------------- illegal opcode ----------------
        bus.opcode = 6'h3F;
        tick();
        check_eq("ill_dec_outs", outs(), 19'b0000_0000_000000_00010);
        check_eq("ill_dec_state", bus.state, 2);
        tick();
        check_eq("ill_next_state", bus.state, 1);
        check_eq("ill_pulse_gone", bus.illegal_op, 0);

        // ---------------- SW with async reset mid-MEM ----------------
        bus.opcode = 6'h2B;
        tick();
        tick();
        bus.mem_ready = 1'b0;
        tick();
        check_eq("sw_mem_ctl", {bus.state, bus.mem_read, bus.mem_write, bus.iord}, {3'd4, 3'b011});
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("sw_rst_wr_drop", bus.mem_write, 0);
        check_eq("sw_rst_outs", outs(), 0);
        check_eq("sw_rst_state", bus.state, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("sw_post_state", bus.state, 0);
        check_eq("sw_post_err", bus.mem_err, 0);

        // ---------------- timeout in FETCH ----------------
        bus.run = 1'b1;
        bus.mem_ready = 1'b0;
        tick();
        for (int i = 1; i <= 16; i++) begin
            check_eq($sformatf("tmo_fetch%0d", i), {bus.state, bus.mem_err}, {3'd1, 1'b0});
            if (i < 16) tick();
        end
        tick();
        check_eq("tmo_idle_state", bus.state, 0);
        check_eq("tmo_idle_outs", outs(), 19'h1);
        for (int i = 0; i < 3; i++) tick();
        check_eq("tmo_run_ignored", {bus.state, bus.mem_err}, {3'd0, 1'b1});
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check_eq("tmo_rst_clears", bus.mem_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- ready on the 16th wait cycle still completes ----------------
        tick();
        check_eq("late_fetch", bus.state, 1);
        for (int i = 2; i <= 16; i++) tick();
        bus.mem_ready = 1'b1;
        #1;
        check_eq("late_fetch16_strobe", {bus.state, bus.ir_write, bus.pc_write}, {3'd1, 2'b11});
        tick();
        check_eq("late_decode", {bus.state, bus.mem_err}, {3'd2, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
